// File: rtl/data_memory.sv
// Word-organised data memory with post-reset clear, sticky illegal-access
// error capture and saturating read/write access counters.
module data_memory #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mem_ctrl_input,
  input  logic [31:0]      address,
  input  logic [31:0]      w_data,
  input  logic             err_clr,
  output logic [31:0]      read_data,
  output logic             busy,
  output logic             err_sticky,
  output logic [31:0]      err_addr,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {CLEAR, READY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          legal;
  logic          ready;
  logic          rd_ok;
  logic          wr_ok;
  logic          illegal;

  always_comb begin
    idx     = address[AW+1:2];
    legal   = (address[1:0] == 2'b00) && (address[31:AW+2] == '0) &&
              (mem_ctrl_input != 2'b11);
    ready   = (state == READY);
    rd_ok   = ready && (mem_ctrl_input == 2'b10) && legal;
    wr_ok   = ready && (mem_ctrl_input == 2'b01) && legal;
    illegal = ready && (mem_ctrl_input != 2'b00) && !legal;
  end

  // Combinational read from the array: a write in the same cycle lands at the
  // edge, so a coincident read still sees the old word.
  always_comb begin
    read_data = '0;
    if (rd_ok) read_data = mem[idx];
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_idx] <= '0;
    else if (wr_ok)
      mem[idx] <= w_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      busy       <= 1'b1;
      err_sticky <= 1'b0;
      err_addr   <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == LAST_IDX) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (rd_ok && rd_count != '1) rd_count <= rd_count + 1'b1;
          if (wr_ok && wr_count != '1) wr_count <= wr_count + 1'b1;
        end
        default: state <= CLEAR;
      endcase

      // An illegal access outranks a coincident clear and is then the one captured.
      if (illegal) begin
        err_sticky <= 1'b1;
        if (!err_sticky || err_clr) err_addr <= address;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
        err_addr   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed, table-driven bench for data_memory (DEPTH=256, narrow counters
// so saturation is reachable quickly).
module tb_data_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam int unsigned CW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mem_ctrl_input;
  logic [31:0]   address;
  logic [31:0]   w_data;
  logic          err_clr;
  logic [31:0]   read_data;
  logic          busy;
  logic          err_sticky;
  logic [31:0]   err_addr;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;

  int n_vec  = 0;
  int n_fail = 0;

  data_memory #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .mem_ctrl_input(mem_ctrl_input),
    .address(address), .w_data(w_data), .err_clr(err_clr),
    .read_data(read_data), .busy(busy), .err_sticky(err_sticky),
    .err_addr(err_addr), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    ctrl;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          clr;
    logic [31:0]   exp_rd;
    logic          exp_err;
    logic [31:0]   exp_eaddr;
    logic [CW-1:0] exp_rdc;
    logic [CW-1:0] exp_wrc;
  } vec_t;

  vec_t vec [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_busy(output int cycles);
    cycles = 0;
    while (busy && cycles < int'(DEPTH) + 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic access(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_ctrl_input = c;
    address        = a;
    w_data         = d;
    err_clr        = 1'b0;
  endtask

  initial begin
    int cyc;

    // idx: ctrl addr wdata clr | exp_rd err eaddr rdc wrc
    vec[0]  = '{2'b10, 32'h0000_0000, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   4'd1, 4'd0};
    vec[1]  = '{2'b01, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 32'h0,   4'd1, 4'd1};
    vec[2]  = '{2'b10, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 32'h0,   4'd2, 4'd1};
    vec[3]  = '{2'b01, 32'h0000_0020, 32'hAAAA_5555, 1'b0, 32'h0,         1'b0, 32'h0,   4'd2, 4'd2};
    vec[4]  = '{2'b01, 32'h0000_0020, 32'h0F0F_0F0F, 1'b0, 32'h0,         1'b0, 32'h0,   4'd2, 4'd3};
    vec[5]  = '{2'b10, 32'h0000_0020, 32'h0,         1'b0, 32'h0F0F_0F0F, 1'b0, 32'h0,   4'd3, 4'd3};
    vec[6]  = '{2'b10, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678, 1'b0, 32'h0,   4'd4, 4'd3};
    vec[7]  = '{2'b10, 32'h0000_0013, 32'h0,         1'b0, 32'h0,         1'b1, 32'h13,  4'd4, 4'd3};
    vec[8]  = '{2'b10, 32'h0000_0400, 32'h0,         1'b0, 32'h0,         1'b1, 32'h13,  4'd4, 4'd3};
    vec[9]  = '{2'b00, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,   4'd4, 4'd3};
    vec[10] = '{2'b01, 32'h0000_0404, 32'h1111_1111, 1'b0, 32'h0,         1'b1, 32'h404, 4'd4, 4'd3};
    vec[11] = '{2'b11, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1, 32'h0,         1'b1, 32'h8,   4'd4, 4'd3};
    vec[12] = '{2'b10, 32'h0000_0008, 32'h0,         1'b0, 32'h0,         1'b1, 32'h8,   4'd5, 4'd3};
    vec[13] = '{2'b00, 32'h0000_0000, 32'h0,         1'b1, 32'h0,         1'b0, 32'h0,   4'd5, 4'd3};
    vec[14] = '{2'b10, 32'h0000_03FC, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   4'd6, 4'd3};
    vec[15] = '{2'b01, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0,         1'b0, 32'h0,   4'd6, 4'd4};
    vec[16] = '{2'b10, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D, 1'b0, 32'h0,   4'd7, 4'd4};
    vec[17] = '{2'b00, 32'h0000_0013, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0,   4'd7, 4'd4};
    vec[18] = '{2'b11, 32'h0000_0004, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,   4'd7, 4'd4};
    vec[19] = '{2'b10, 32'h1000_0010, 32'h0,         1'b0, 32'h0,         1'b1, 32'h4,   4'd7, 4'd4};

    // Reset with a write held on the port for the whole clear.
    reset          = 1'b1;
    mem_ctrl_input = 2'b01;
    address        = 32'h0;
    w_data         = 32'hDEAD_BEEF;
    err_clr        = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd1);
    chk("rst_err", {31'b0, err_sticky}, 32'd0);
    chk("rst_eaddr", err_addr, 32'h0);
    chk("rst_rdc", {28'b0, rd_count}, 32'd0);
    chk("rst_wrc", {28'b0, wr_count}, 32'd0);
    chk("rst_rdata", read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_busy(cyc);
    mem_ctrl_input = 2'b00;
    chk("busy_cycles", cyc, DEPTH);
    chk("busy_wrc", {28'b0, wr_count}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ctrl_input = vec[i].ctrl;
      address        = vec[i].addr;
      w_data         = vec[i].wdata;
      err_clr        = vec[i].clr;
      #1;
      chk($sformatf("v%0d_rdata", i), read_data, vec[i].exp_rd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_err", i), {31'b0, err_sticky}, {31'b0, vec[i].exp_err});
      chk($sformatf("v%0d_eaddr", i), err_addr, vec[i].exp_eaddr);
      chk($sformatf("v%0d_rdc", i), {28'b0, rd_count}, {28'b0, vec[i].exp_rdc});
      chk($sformatf("v%0d_wrc", i), {28'b0, wr_count}, {28'b0, vec[i].exp_wrc});
    end

    // Saturation: wr_count goes 4 -> 15 and holds, rd_count 7 -> 15 and holds.
    for (int i = 0; i < 15; i++) access(2'b01, 32'h24, i);
    for (int i = 0; i < 10; i++) access(2'b10, 32'h10, 32'h0);
    access(2'b10, 32'h24, 32'h0);
    #1;
    chk("sat_rdata", read_data, 32'd14);
    @(posedge clk);
    #1;
    chk("sat_wrc", {28'b0, wr_count}, 32'd15);
    chk("sat_rdc", {28'b0, rd_count}, 32'd15);

    // Reset after READY writes, then again midway through the clear.
    @(negedge clk);
    mem_ctrl_input = 2'b00;
    reset = 1'b1;
    #1;
    chk("rst2_busy", {31'b0, busy}, 32'd1);
    chk("rst2_err", {31'b0, err_sticky}, 32'd0);
    chk("rst2_rdc", {28'b0, rd_count}, 32'd0);
    chk("rst2_wrc", {28'b0, wr_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wait_busy(cyc);
    chk("busy_cycles2", cyc, DEPTH);
    access(2'b10, 32'h10, 32'h0);
    #1;
    chk("clr_0x10", read_data, 32'h0);
    access(2'b10, 32'h24, 32'h0);
    #1;
    chk("clr_0x24", read_data, 32'h0);
    access(2'b10, 32'h3FC, 32'h0);
    #1;
    chk("clr_0x3fc", read_data, 32'h0);
    @(posedge clk);
    #1;
    chk("clr_rdc", {28'b0, rd_count}, 32'd3);
    chk("clr_err", {31'b0, err_sticky}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
